// File: rtl/collision_tracker_if.sv
// rtl/collision_tracker_if.sv - position inputs and game status outputs of the collision tracker
// master drives positions and strobes; slave is the tracker itself.
interface collision_tracker_if #(
  parameter int COORD_W   = 4,
  parameter int NUM_PIPES = 2,
  parameter int SCORE_W   = 8
);
  logic                           start;
  logic                           tick;
  logic [COORD_W-1:0]             BirdY;
  logic [NUM_PIPES*COORD_W-1:0]   PipeX;
  logic [NUM_PIPES*COORD_W-1:0]   GapY;
  logic                           Playing;
  logic                           GameOver;
  logic                           Hit;
  logic                           ScoreInc;
  logic [SCORE_W-1:0]             Score;

  modport master (
    output start, tick, BirdY, PipeX, GapY,
    input  Playing, GameOver, Hit, ScoreInc, Score
  );

  modport slave (
    input  start, tick, BirdY, PipeX, GapY,
    output Playing, GameOver, Hit, ScoreInc, Score
  );
endinterface

// File: rtl/collision_tracker.sv
// rtl/collision_tracker.sv - multi-pipe bird collision check, game state and saturating score
// All evaluation happens on tick in PLAY; every output is registered (latency 1).
module collision_tracker #(
  parameter int COORD_W   = 4,
  parameter int NUM_PIPES = 2,
  parameter int GAP_SIZE  = 4,
  parameter int BIRD_X    = 12,
  parameter int SCORE_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  collision_tracker_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_PIPES + 1);
  localparam int SUM_W = SCORE_W + CNT_W;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t               state;
  logic [NUM_PIPES-1:0] scored;
  logic                 playing_q, gameover_q, hit_q, inc_q;
  logic [SCORE_W-1:0]   score_q;

  logic [NUM_PIPES-1:0] at, in_gap, fresh;
  logic                 any_hit;
  logic [CNT_W-1:0]     new_cnt;
  logic [COORD_W-1:0]   px, gy;
  logic [COORD_W:0]     gap_end;
  logic [SUM_W-1:0]     score_sum;
  logic [SCORE_W-1:0]   score_next;

  // Gap end is formed one bit wider so a gap near the top row never wraps to row 0.
  always_comb begin
    any_hit = (bus.BirdY == '0) || (bus.BirdY == '1);
    new_cnt = '0;
    at      = '0;
    in_gap  = '0;
    fresh   = '0;
    px      = '0;
    gy      = '0;
    gap_end = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      px        = bus.PipeX[i*COORD_W +: COORD_W];
      gy        = bus.GapY[i*COORD_W +: COORD_W];
      gap_end   = {1'b0, gy} + (COORD_W+1)'(GAP_SIZE);
      at[i]     = (px == COORD_W'(BIRD_X));
      in_gap[i] = ({1'b0, bus.BirdY} >= {1'b0, gy}) && ({1'b0, bus.BirdY} < gap_end);
      if (at[i] && !in_gap[i])
        any_hit = 1'b1;
      fresh[i]  = at[i] && in_gap[i] && !scored[i];
      new_cnt   = new_cnt + CNT_W'(fresh[i]);
    end
    score_sum  = SUM_W'(score_q) + SUM_W'(new_cnt);
    score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      scored     <= '0;
      playing_q  <= 1'b0;
      gameover_q <= 1'b0;
      hit_q      <= 1'b0;
      inc_q      <= 1'b0;
      score_q    <= '0;
    end else begin
      hit_q <= 1'b0;
      inc_q <= 1'b0;
      case (state)
        IDLE, OVER: begin
          // A tick coinciding with start only opens the game; it is not evaluated.
          if (bus.start) begin
            state      <= PLAY;
            score_q    <= '0;
            scored     <= '0;
            playing_q  <= 1'b1;
            gameover_q <= 1'b0;
          end
        end
        PLAY: begin
          if (bus.tick) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
              if (!at[i])
                scored[i] <= 1'b0;
              else if (in_gap[i] && !any_hit)
                scored[i] <= 1'b1;
            end
            if (any_hit) begin
              state      <= OVER;
              hit_q      <= 1'b1;
              playing_q  <= 1'b0;
              gameover_q <= 1'b1;
            end else if (new_cnt != '0) begin
              score_q <= score_next;
              inc_q   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Playing  = playing_q;
  assign bus.GameOver = gameover_q;
  assign bus.Hit      = hit_q;
  assign bus.ScoreInc = inc_q;
  assign bus.Score    = score_q;

endmodule

// File: tb/tb_collision_tracker.sv
// tb/tb_collision_tracker.sv - directed scoreboard bench for collision_tracker
// A second instance with a 2-bit score shares the inputs to exercise saturation.
module tb_collision_tracker;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  collision_tracker_if #(.COORD_W(4), .NUM_PIPES(2), .SCORE_W(8)) mif ();
  collision_tracker_if #(.COORD_W(4), .NUM_PIPES(2), .SCORE_W(2)) sif ();

  assign sif.start = mif.start;
  assign sif.tick  = mif.tick;
  assign sif.BirdY = mif.BirdY;
  assign sif.PipeX = mif.PipeX;
  assign sif.GapY  = mif.GapY;

  collision_tracker #(.COORD_W(4), .NUM_PIPES(2), .GAP_SIZE(4), .BIRD_X(12), .SCORE_W(8))
    dut (.clk(clk), .reset(reset), .bus(mif));

  collision_tracker #(.COORD_W(4), .NUM_PIPES(2), .GAP_SIZE(4), .BIRD_X(12), .SCORE_W(2))
    dut_sat (.clk(clk), .reset(reset), .bus(sif));

  typedef struct {
    string      tag;
    logic       playing;
    logic       gameover;
    logic       hit;
    logic       inc;
    logic [7:0] score;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".playing"},  {7'b0, mif.Playing},  {7'b0, e.playing});
      chk({e.tag, ".gameover"}, {7'b0, mif.GameOver}, {7'b0, e.gameover});
      chk({e.tag, ".hit"},      {7'b0, mif.Hit},      {7'b0, e.hit});
      chk({e.tag, ".inc"},      {7'b0, mif.ScoreInc}, {7'b0, e.inc});
      chk({e.tag, ".score"},    mif.Score,            e.score);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge evaluate, compare just after it.
  task automatic step(input logic r, input logic st, input logic tk,
                      input logic [3:0] by, input logic [3:0] p0, input logic [3:0] g0,
                      input logic [3:0] p1, input logic [3:0] g1, input string tag,
                      input logic ep, input logic eo, input logic eh, input logic ei,
                      input logic [7:0] es);
    exp_t e;
    reset     = r;
    mif.start = st;
    mif.tick  = tk;
    mif.BirdY = by;
    mif.PipeX = {p1, p0};
    mif.GapY  = {g1, g0};
    e.tag = tag; e.playing = ep; e.gameover = eo; e.hit = eh; e.inc = ei; e.score = es;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mif.start = 1'b0;
    mif.tick  = 1'b0;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    mif.start = 1'b0;
    mif.tick  = 1'b0;
    mif.BirdY = 4'd7;
    mif.PipeX = '0;
    mif.GapY  = '0;
    @(negedge clk);

    //    r  st tk  by  p0  g0  p1  g1  tag              ply ovr hit inc score
    step(1, 0, 0, 7,  0,  6,  0,  0, "reset",          0,  0,  0,  0,  8'd0);
    step(0, 0, 1, 7,  12, 6,  0,  0, "idle_tick",      0,  0,  0,  0,  8'd0);
    step(0, 1, 1, 7,  12, 6,  0,  0, "start_tick",     1,  0,  0,  0,  8'd0);
    step(0, 0, 1, 7,  12, 6,  0,  0, "first_clear",    1,  0,  0,  1,  8'd1);
    step(0, 0, 1, 7,  12, 6,  0,  0, "stay1",          1,  0,  0,  0,  8'd1);
    step(0, 1, 1, 7,  12, 6,  0,  0, "stay2_start",    1,  0,  0,  0,  8'd1);
    step(0, 0, 1, 7,  12, 6,  0,  0, "stay3",          1,  0,  0,  0,  8'd1);
    step(0, 0, 1, 7,  11, 6,  0,  0, "pipe_left",      1,  0,  0,  0,  8'd1);
    step(0, 0, 1, 8,  12, 6,  0,  0, "second_clear",   1,  0,  0,  1,  8'd2);
    step(0, 0, 1, 4,  12, 6,  0,  0, "pipe_hit",       0,  1,  1,  0,  8'd2);
    step(0, 0, 1, 7,  12, 6,  0,  0, "over_tick",      0,  1,  0,  0,  8'd2);
    step(0, 1, 0, 7,  0,  6,  0,  0, "restart",        1,  0,  0,  0,  8'd0);
    step(0, 0, 1, 14, 12, 14, 0,  0, "wrap_in_gap",    1,  0,  0,  1,  8'd1);
    step(0, 0, 1, 14, 11, 14, 0,  0, "wrap_leave",     1,  0,  0,  0,  8'd1);
    step(0, 0, 1, 2,  12, 14, 0,  0, "wrap_hit",       0,  1,  1,  0,  8'd1);
    step(0, 1, 0, 7,  0,  6,  0,  0, "restart2",       1,  0,  0,  0,  8'd0);
    step(0, 0, 1, 7,  12, 6,  12, 5, "dual_clear",     1,  0,  0,  1,  8'd2);
    step(0, 0, 1, 7,  0,  6,  0,  5, "dual_leave",     1,  0,  0,  0,  8'd2);
    step(0, 0, 1, 7,  12, 6,  12, 0, "clear_and_hit",  0,  1,  1,  0,  8'd2);
    step(0, 1, 0, 7,  0,  6,  0,  0, "restart3",       1,  0,  0,  0,  8'd0);
    step(0, 0, 1, 0,  0,  6,  0,  0, "floor_hit",      0,  1,  1,  0,  8'd0);
    step(0, 1, 0, 7,  0,  6,  0,  0, "restart4",       1,  0,  0,  0,  8'd0);
    step(0, 0, 1, 15, 0,  6,  0,  0, "ceiling_hit",    0,  1,  1,  0,  8'd0);
    step(0, 1, 0, 7,  0,  6,  0,  0, "restart5",       1,  0,  0,  0,  8'd0);

    for (int n = 1; n <= 4; n++) begin
      step(0, 0, 1, 7, 12, 6, 0, 0, "sat_clear", 1, 0, 0, 1, 8'(n));
      chk("sat_score", {6'b0, sif.Score}, (n >= 3) ? 8'd3 : 8'(n));
      chk("sat_inc",   {7'b0, sif.ScoreInc}, 8'd1);
      step(0, 0, 1, 7, 0, 6, 0, 0, "sat_leave", 1, 0, 0, 0, 8'(n));
    end

    step(1, 1, 1, 7,  12, 6,  0,  0, "reset_mid_play", 0,  0,  0,  0,  8'd0);
    chk("sat_reset_score", {6'b0, sif.Score}, 8'd0);
    step(0, 0, 1, 7,  12, 6,  0,  0, "idle_after_rst", 0,  0,  0,  0,  8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
